// File: rtl/d_pipe_pkg.sv
// ----------------------------------------------------------------------------
// d_pipe_pkg
//
// Purpose
//   Shared definitions for the d_pipe_register delay line:
//     - cnt_w()       width of the occupancy counter for a given depth
//     - pipe_act_e    the one action the pipeline takes at a clock edge
//     - decode_act()  maps the flush/en control pair onto that action
//
// The per-stage record {vld, data} depends on WIDTH, so it is declared as a
// packed struct inside each module that needs it rather than here.
// ----------------------------------------------------------------------------
package d_pipe_pkg;

    // Action taken by every stage and by the counter at a rising edge.
    // Flush dominates advance, advance dominates hold.
    typedef enum logic [1:0] {
        ACT_HOLD  = 2'd0,
        ACT_SHIFT = 2'd1,
        ACT_FLUSH = 2'd2
    } pipe_act_e;

    // Bits needed to represent an occupancy in the range 0..depth.
    function automatic int cnt_w(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    function automatic pipe_act_e decode_act(input logic flush, input logic en);
        if (flush) begin
            return ACT_FLUSH;
        end
        if (en) begin
            return ACT_SHIFT;
        end
        return ACT_HOLD;
    endfunction

endpackage : d_pipe_pkg

// File: rtl/d_pipe_stage.sv
// ----------------------------------------------------------------------------
// d_pipe_stage
//
// Purpose
//   One stage of the delay line: a WIDTH-bit data register plus its valid
//   bit, stored together as a single WIDTH+1-bit record.
//
// Ports
//   clk      in   1      rising-edge clock
//   rst      in   1      asynchronous reset, active-low
//   en       in   1      load {d_valid, d} this edge
//   clr      in   1      clear the valid bit only; has priority over en
//   d        in   WIDTH  data from the previous stage (or the pipe input)
//   d_valid  in   1      valid bit from the previous stage (or the pipe input)
//   q        out  WIDTH  stored data
//   q_valid  out  1      stored valid bit
// ----------------------------------------------------------------------------
module d_pipe_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] data;
    } stage_t;

    stage_t stage_q;

    // NOTE: sequential state is written with non-blocking assignments so that
    // every stage samples its neighbour's pre-edge value; blocking writes here
    // would let data ripple through several stages in one clock.
    //
    // NOTE: the data field is reset as well as the valid bit, because the
    // pipe output must read RESET_VAL immediately after reset, not whatever
    // was last shifted through.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_q.vld  <= 1'b0;
            stage_q.data <= RESET_VAL;
        end else if (clr) begin
            // Flush only invalidates; the data field keeps its old contents.
            stage_q.vld  <= 1'b0;
        end else if (en) begin
            stage_q.vld  <= d_valid;
            stage_q.data <= d;
        end
    end

    assign q       = stage_q.data;
    assign q_valid = stage_q.vld;

endmodule : d_pipe_stage

// File: rtl/d_pipe_register.sv
// ----------------------------------------------------------------------------
// d_pipe_register
//
// Purpose
//   Stallable, flushable multi-stage D-register delay line with per-stage
//   valid tracking and an occupancy count. With en held high, an input
//   appears on q/q_valid DEPTH rising edges after it was presented.
//   Data moves through every stage regardless of its valid bit; invalid
//   slots (bubbles) carry data with vld = 0.
//
// Parameters
//   WIDTH      data bits per stage (>= 1)
//   DEPTH      number of stages = latency in advancing cycles (>= 1)
//   RESET_VAL  data value loaded into every stage on reset
//
// Ports
//   clk      in   1                rising-edge clock
//   rst      in   1                asynchronous reset, active-low
//   en       in   1                advance the pipeline this edge
//   flush    in   1                synchronous clear of all valid bits
//   d        in   WIDTH            input data
//   d_valid  in   1                input data qualifier
//   q        out  WIDTH            data of the last stage
//   q_valid  out  1                valid bit of the last stage
//   count    out  clog2(DEPTH+1)   number of stages holding valid data
//   full     out  1                count == DEPTH
//   empty    out  1                count == 0
//
// Edge priority: flush > en > hold. q and q_valid come straight from the
// last stage register, so there is no combinational path from any input.
// ----------------------------------------------------------------------------
module d_pipe_register
    import d_pipe_pkg::*;
#(
    parameter  int               WIDTH     = 8,
    parameter  int               DEPTH     = 4,
    parameter  logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int               CNT_W     = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    // ------------------------------------------------------------------
    // Edge action, shared by every stage and the occupancy counter so the
    // two can never disagree about what happened at a given edge.
    // ------------------------------------------------------------------
    pipe_act_e act;
    logic      stage_en;
    logic      stage_clr;

    assign act       = decode_act(flush, en);
    assign stage_en  = (act == ACT_SHIFT);
    assign stage_clr = (act == ACT_FLUSH);

    // ------------------------------------------------------------------
    // Stage chain: stage 0 takes the pipe input, stage i takes stage i-1.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [DEPTH-1:0] stage_vld;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] din;
        logic             din_vld;

        if (i == 0) begin : g_head
            assign din     = d;
            assign din_vld = d_valid;
        end else begin : g_link
            assign din     = stage_data[i-1];
            assign din_vld = stage_vld[i-1];
        end

        d_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en      (stage_en),
            .clr     (stage_clr),
            .d       (din),
            .d_valid (din_vld),
            .q       (stage_data[i]),
            .q_valid (stage_vld[i])
        );
    end : g_stage

    assign q       = stage_data[DEPTH-1];
    assign q_valid = stage_vld[DEPTH-1];

    // ------------------------------------------------------------------
    // Occupancy counter. It tracks the popcount of stage_vld incrementally:
    // on an advance one slot enters (d_valid) and one leaves (last vld).
    // When the pipe is full and a valid word enters, the last stage is
    // necessarily valid too, so the sum stays within 0..DEPTH and the
    // CNT_W-bit arithmetic never wraps.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] count_nxt;

    // NOTE: count_nxt gets a default before the case so every path through
    // this block assigns it; a missing default would infer a latch.
    always_comb begin
        count_nxt = count;
        unique case (act)
            ACT_FLUSH: count_nxt = '0;
            ACT_SHIFT: count_nxt = count + CNT_W'(d_valid) - CNT_W'(stage_vld[DEPTH-1]);
            default:   count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule : d_pipe_register

// File: tb/tb_d_pipe_register.sv
// ----------------------------------------------------------------------------
// tb_d_pipe_register
//
// Bench for d_pipe_register (WIDTH=8, DEPTH=4). A reference model keeps the
// in-flight words as a list of {data, position}: each advance moves every
// word one position on and drops those past the last stage; a flush or
// reset empties the list. After every clock edge (and on async reset) the
// model pushes the expected output {q_valid, q, count} into a scoreboard
// queue, and a monitor on the falling edge pops and compares. Directed
// scenarios add their own spot checks on top.
// ----------------------------------------------------------------------------
module tb_d_pipe_register;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst;
    logic             en;
    logic             flush;
    logic [WIDTH-1:0] d;
    logic             d_valid;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;

    int n_checks = 0;
    int n_fail   = 0;

    d_pipe_register #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL ('0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .flush   (flush),
        .d       (d),
        .d_valid (d_valid),
        .q       (q),
        .q_valid (q_valid),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        logic [WIDTH-1:0] data;
        int               pos;
    } item_t;

    typedef struct {
        logic             vld;
        logic [WIDTH-1:0] data;
        int               cnt;
    } out_t;

    item_t flight[$];
    item_t nxt[$];
    item_t it;
    out_t  exp_q[$];
    out_t  rec;
    out_t  cur;

    always @(posedge clk or negedge rst) begin
        if (!rst || flush) begin
            flight.delete();
        end else if (en) begin
            nxt.delete();
            foreach (flight[i]) begin
                if (flight[i].pos + 1 < DEPTH) begin
                    it     = flight[i];
                    it.pos = it.pos + 1;
                    nxt.push_back(it);
                end
            end
            if (d_valid) begin
                it.data = d;
                it.pos  = 0;
                nxt.push_back(it);
            end
            flight = nxt;
        end
        rec.vld  = 1'b0;
        rec.data = '0;
        rec.cnt  = flight.size();
        foreach (flight[i]) begin
            if (flight[i].pos == DEPTH - 1) begin
                rec.vld  = 1'b1;
                rec.data = flight[i].data;
            end
        end
        // A reset invalidates anything the monitor has not yet consumed.
        if (!rst) exp_q.delete();
        exp_q.push_back(rec);
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            check("sb_q_valid", 32'(q_valid), 32'(cur.vld));
            if (cur.vld) check("sb_q", 32'(q), 32'(cur.data));
            check("sb_count", 32'(count), 32'(cur.cnt));
            check("sb_full", 32'(full), 32'(cur.cnt == DEPTH));
            check("sb_empty", 32'(empty), 32'(cur.cnt == 0));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drive(input logic e, input logic f, input logic v, input logic [WIDTH-1:0] dd);
        en      = e;
        flush   = f;
        d_valid = v;
        d       = dd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        drive(1'b0, 1'b1, 1'b0, '0);
        tick();
        check("flush_empty", 32'(empty), 32'd1);
    endtask

    logic [WIDTH-1:0] base;

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0);
        tick();
        tick();

        // Reset state
        check("rst_q", 32'(q), 32'h00);
        check("rst_q_valid", 32'(q_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        rst = 1'b1;
        tick();

        // 1. Asynchronous reset mid-stream with three valid stages
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 1'b1, WIDTH'(8'h51 + k));
            tick();
        end
        check("t1_count_pre", 32'(count), 32'd3);
        drive(1'b0, 1'b0, 1'b0, '0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("t1_q", 32'(q), 32'h00);
        check("t1_q_valid", 32'(q_valid), 32'd0);
        check("t1_count", 32'(count), 32'd0);
        check("t1_empty", 32'(empty), 32'd1);
        tick();
        rst = 1'b1;
        tick();

        // 2. Latency and fill: A1..A6 with en held high
        do_flush();
        for (int k = 1; k <= 6; k++) begin
            drive(1'b1, 1'b0, 1'b1, WIDTH'(8'hA0 + k));
            tick();
            check("t2_count", 32'(count), 32'((k < DEPTH) ? k : DEPTH));
            check("t2_full", 32'(full), 32'(k >= DEPTH));
            if (k >= DEPTH) begin
                check("t2_q_valid", 32'(q_valid), 32'd1);
                check("t2_q", 32'(q), 32'(8'hA0 + k - DEPTH + 1));
            end else begin
                check("t2_q_valid_early", 32'(q_valid), 32'd0);
            end
        end

        // 3. Stall with two valid words in flight, then resume
        do_flush();
        drive(1'b1, 1'b0, 1'b1, 8'hB1);
        tick();
        drive(1'b1, 1'b0, 1'b1, 8'hB2);
        tick();
        drive(1'b0, 1'b0, 1'b1, 8'hEE);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t3_stall_count", 32'(count), 32'd2);
            check("t3_stall_q_valid", 32'(q_valid), 32'd0);
        end
        drive(1'b1, 1'b0, 1'b0, '0);
        tick();
        check("t3_resume_q_valid", 32'(q_valid), 32'd0);
        tick();
        check("t3_first_q_valid", 32'(q_valid), 32'd1);
        check("t3_first_q", 32'(q), 32'hB1);
        tick();
        check("t3_second_q", 32'(q), 32'hB2);
        check("t3_second_count", 32'(count), 32'd1);
        tick();
        check("t3_drained", 32'(count), 32'd0);

        // 4. Bubbles: valid pattern 1,0,1,0 on 11,22,33,44
        do_flush();
        for (int k = 1; k <= 8; k++) begin
            if (k <= 4) drive(1'b1, 1'b0, 1'b1 ^ (k % 2 == 0), WIDTH'(8'h11 * k));
            else        drive(1'b1, 1'b0, 1'b0, '0);
            tick();
            if (k <= 4) check("t4_count", 32'(count), 32'((k + 1) / 2));
            if (k >= 4 && k <= 7) begin
                check("t4_q_valid", 32'(q_valid), 32'(k % 2 == 0));
                if (k % 2 == 0) check("t4_q", 32'(q), 32'(8'h11 * (k - 3)));
            end
        end

        // 5. Flush colliding with a valid input on a full pipe
        do_flush();
        for (int k = 1; k <= DEPTH; k++) begin
            drive(1'b1, 1'b0, 1'b1, WIDTH'(8'hC0 + k));
            tick();
        end
        check("t5_full", 32'(full), 32'd1);
        drive(1'b1, 1'b1, 1'b1, 8'hFF);
        tick();
        check("t5_count", 32'(count), 32'd0);
        check("t5_empty", 32'(empty), 32'd1);
        check("t5_q_valid", 32'(q_valid), 32'd0);
        drive(1'b1, 1'b0, 1'b0, '0);
        for (int k = 0; k < DEPTH + 1; k++) begin
            tick();
            check("t5_no_ff", 32'(q_valid), 32'd0);
        end

        // 6. Random traffic, checked entirely by the scoreboard
        for (int k = 0; k < 1000; k++) begin
            base = WIDTH'($urandom);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                  1'($urandom_range(0, 1)), base);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, '0);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_d_pipe_register
